// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Define MDU_FAST_MUL_EN to use a single-cycle multiplier in place of the shift-add one.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic is_div, neg_a, neg_b;
  logic [WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] p, p_nxt, prod;
  logic [CW-1:0] cnt;
  logic sgn, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem, res_hi, res_lo;
  logic [WIDTH:0] sum, t, d;
  always_comb begin
    sgn = ~op[0];
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    abs_a = a_neg ? -a : a;
    abs_b = b_neg ? -b : b;
    b_zero = (b == '0);
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mb} : '0);
    t = p[2*WIDTH-1:WIDTH-1];
    d = t - {1'b0, mb};
    p_nxt = is_div ? (d[WIDTH] ? {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {d[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                   : {sum, p[WIDTH-1:1]};
    prod = (neg_a ^ neg_b) ? -p_nxt : p_nxt;
    quo = (neg_a ^ neg_b) ? -p_nxt[WIDTH-1:0] : p_nxt[WIDTH-1:0];
    rem = neg_a ? -p_nxt[2*WIDTH-1:WIDTH] : p_nxt[2*WIDTH-1:WIDTH];
    res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = is_div ? quo : prod[WIDTH-1:0];
  end
`ifdef MDU_FAST_MUL_EN
  // sign/zero extension makes one modular 2W-bit multiply serve both MULT and MULTU
  logic [2*WIDTH-1:0] xa, xb, fast_p;
  assign xa = {{WIDTH{a_neg}}, a};
  assign xb = {{WIDTH{b_neg}}, b};
  assign fast_p = xa * xb;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      p <= '0;
      mb <= '0;
      is_div <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == CALC) begin
        if (cancel) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          p <= p_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            hi <= res_hi;
            lo <= res_lo;
          end
        end
      end else if (start && !cancel) begin
        is_div <= op[1];
        neg_a <= a_neg;
        neg_b <= b_neg;
        mb <= abs_b;
        cnt <= '0;
        div_by_zero <= op[1] & b_zero;
        if (op[1] && b_zero) begin
          state <= DONE;
          done <= 1'b1;
          hi <= a;
          lo <= '1;
        end
`ifdef MDU_FAST_MUL_EN
        else if (!op[1]) begin
          state <= DONE;
          done <= 1'b1;
          {hi, lo} <= fast_p;
        end
`endif
        else begin
          state <= CALC;
          busy <= 1'b1;
          p <= {{WIDTH{1'b0}}, abs_a};
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized self-checking bench for mul_div_unit against a countdown reference model.
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, resetn, start = 1'b0, cancel = 1'b0;
  logic [1:0] op = 2'b0;
  logic [W-1:0] a = '0, b = '0, hi, lo;
  logic busy, done, dz;
  logic start8 = 1'b0, cancel8 = 1'b0;
  logic [1:0] op8 = 2'b0;
  logic [7:0] a8 = '0, b8 = '0, hi8, lo8;
  logic busy8, done8, dz8;
  int checks = 0, failures = 0, ndone = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dz)
  );
  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(cancel8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sx, sy;
    logic [63:0] pr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    z = 1'b0;
    h = '0;
    l = '0;
    if (o[1] && y == 0) begin
      z = 1'b1;
      h = x;
      l = '1;
    end else begin
      case (o)
        2'b00: begin pr = 64'(sx * sy); h = pr[63:32]; l = pr[31:0]; end
        2'b01: begin pr = {32'b0, x} * {32'b0, y}; h = pr[63:32]; l = pr[31:0]; end
        2'b10: begin l = 32'(sx / sy); h = 32'(sx % sy); end
        default: begin l = x / y; h = x % y; end
      endcase
    end
  endfunction

  // reference: counts down the remaining edges of the operation in flight
  int rem_m = 0;
  logic busy_m = 1'b0, done_m = 1'b0, dz_m = 1'b0;
  logic [31:0] hi_m = '0, lo_m = '0, ph = '0, pl = '0, th, tl;
  logic tz;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_m <= 0; busy_m <= 1'b0; done_m <= 1'b0; dz_m <= 1'b0; hi_m <= '0; lo_m <= '0;
    end else begin
      done_m <= 1'b0;
      if (rem_m > 0) begin
        if (cancel) begin
          rem_m <= 0; busy_m <= 1'b0;
        end else begin
          rem_m <= rem_m - 1;
          if (rem_m == 1) begin done_m <= 1'b1; busy_m <= 1'b0; hi_m <= ph; lo_m <= pl; end
        end
      end else if (start && !cancel) begin
        ref_op(op, a, b, th, tl, tz);
        dz_m <= tz;
        if (tz || (FAST && !op[1])) begin
          done_m <= 1'b1; hi_m <= th; lo_m <= tl;
        end else begin
          rem_m <= W; busy_m <= 1'b1; ph <= th; pl <= tl;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) ndone++;
    if (en) begin
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      chk("hi", hi, hi_m);
      chk("lo", lo, lo_m);
      chk("div_by_zero", dz, dz_m);
    end
  end

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input bit glitch, output int n);
    start = 1'b1; op = o; a = x; b = y; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        start = glitch & n[0];
        if (glitch) begin a = 32'd7; b = 32'd0; end
      end
    end while (!done && n < 200);
    start = 1'b0;
    chk("run_done", done, 1);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int n, sx, sy, lat;
    logic [15:0] e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o[1] && y == 0) e = {x, 8'hff};
    else case (o)
      2'b00: e = 16'(sx * sy);
      2'b01: e = {8'b0, x} * {8'b0, y};
      2'b10: e = {8'(sx % sy), 8'(sx / sy)};
      default: e = {x % y, x / y};
    endcase
    lat = ((o[1] && y == 0) || (FAST && !o[1])) ? 1 : 9;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y; n = 0;
    do begin
      @(negedge clk);
      n++;
      start8 = 1'b0;
    end while (!done8 && n < 50);
    chk("w8_lat", n, lat);
    chk("w8_hilo", {hi8, lo8}, e);
    chk("w8_dz", dz8, o[1] && y == 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n, nd0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_dz", dz, 0);
    #1 resetn = 1'b1;
    en = 1'b1;
    @(negedge clk);
    run(2'b11, 32'd100, 32'd7, 1'b0, n);
    chk("divu_lat", n, 33); chk("divu_lo", lo, 14); chk("divu_hi", hi, 2);
    run(2'b10, 32'hffff_fff9, 32'd2, 1'b0, n);
    chk("div_b2b_lat", n, 33); chk("div_lo", lo, 32'hffff_fffd); chk("div_hi", hi, 32'hffff_ffff);
    run(2'b00, 32'hffff_ffff, 32'd2, 1'b0, n);
    chk("mult_lat", n, FAST ? 1 : 33); chk("mult_hi", hi, 32'hffff_ffff); chk("mult_lo", lo, 32'hffff_fffe);
    run(2'b01, 32'hffff_ffff, 32'd2, 1'b0, n);
    chk("multu_lat", n, FAST ? 1 : 33); chk("multu_hi", hi, 1); chk("multu_lo", lo, 32'hffff_fffe);
    run(2'b11, 32'd5, 32'd0, 1'b0, n);
    chk("dbz_lat", n, 1); chk("dbz_flag", dz, 1); chk("dbz_lo", lo, 32'hffff_ffff); chk("dbz_hi", hi, 5);
    run(2'b10, 32'h8000_0000, 32'hffff_ffff, 1'b0, n);
    chk("ovf_lat", n, 33); chk("ovf_lo", lo, 32'h8000_0000); chk("ovf_hi", hi, 0); chk("ovf_dz", dz, 0);
    run(2'b11, 32'd1000, 32'd3, 1'b1, n);
    chk("busy_start_lat", n, 33); chk("busy_start_lo", lo, 333); chk("busy_start_hi", hi, 1);
    @(negedge clk);
    nd0 = ndone;
    start = 1'b1; op = 2'b10; a = 32'd1234; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    repeat (40) @(negedge clk);
    chk("cancel_nodone", ndone - nd0, 0); chk("cancel_lo", lo, 333); chk("cancel_hi", hi, 1);
    start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0); chk("midrst_hilo", {hi, lo}, 0);
    #1 resetn = 1'b1;
    nd0 = ndone;
    repeat (40) @(negedge clk);
    chk("midrst_nodone", ndone - nd0, 0); chk("midrst_hilo_after", {hi, lo}, 0);
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op = 2'($urandom);
      a = pick();
      b = pick();
      cancel = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    cancel = 1'b0;
    repeat (40) @(negedge clk);
    run8(2'b11, 8'd200, 8'd9);
    chk("w8_divu_lo", lo8, 22);
    chk("w8_divu_hi", hi8, 2);
    run8(2'b10, 8'h80, 8'hff);
    run8(2'b10, 8'h05, 8'h00);
    for (int i = 0; i < 40; i++) begin
      run8(2'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit that executes MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO results.
- Sits beside the combinational ALU in the execute stage.
- The pipeline issues an operation with a start pulse and stalls on busy; results are presented on hi/lo together with a one-cycle done pulse.
- Generalises the ALU's single-cycle datapath to a WIDTH-configurable, multi-cycle engine with a handshake and cancel support.

Parameters:
- WIDTH, 32, operand and result width (supported range 8..64, even)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- op  in  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- cancel  in  1  flush (exception / branch squash); aborts operation in progress
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse, hi/lo valid and updated
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- div_by_zero  out  1  high with done when a divide had b=0; cleared on next accepted start

Behaviour:
- Reset (resetn=0, async): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0. Reset mid-operation discards the operation with no done.
- States:
  - IDLE: busy=0. start=1 and cancel=0 → latch op/a/b, go to CALC.
  - CALC: busy=1. Run one radix-2 step per cycle for WIDTH cycles, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, hi/lo written at the edge entering DONE. A new start is accepted in the DONE cycle, giving back-to-back issue.
- Latency: done is high in the cycle after WIDTH+1 rising edges from the edge that sampled start.
- Start while busy=1 is ignored; operands are not re-latched.
- Signed ops:
  - Operands are converted to magnitudes and an unsigned core is run.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
- DIV/DIVU: lo = quotient, hi = remainder. Restoring shift-subtract algorithm.
- Divide by zero (b=0):
  - CALC is skipped; IDLE→DONE on the accepting edge, so done is in the next cycle.
  - lo = all ones, hi = a, div_by_zero=1.
- Signed overflow (DIV of most-negative / -1): lo = most-negative value (wraps), hi=0. No flag.
- cancel=1 in CALC: go to IDLE at the next edge; no done; hi/lo keep their prior values.
- cancel=1 together with start in IDLE/DONE: cancel wins, start is ignored.
- cancel in the DONE cycle: the done pulse and the hi/lo update already committed are unaffected.
- hi/lo hold their value between done pulses.

Optional Feature:
- Macro: MDU_FAST_MUL_EN
- Defined: MULT/MULTU compute the product combinationally from the latched operands. IDLE→DONE directly, so done occurs one cycle after start (same timing as divide-by-zero). Divide is unchanged.
- Undefined: multiply uses an iterative shift-add over WIDTH CALC cycles, with the same latency as divide. No multiplier is inferred.

Test Plan:
- Reset/idle: assert resetn=0 during CALC of a DIVU → busy=0, done never pulses, hi=lo=0 after release.
- DIVU and DIV, WIDTH=32:
  - a=100, b=7 → done at edge 33; lo=14, hi=2.
  - DIV with a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- MULT/MULTU:
  - MULT a=0xFFFFFFFF, b=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU a=0xFFFFFFFF, b=2 → hi=1, lo=0xFFFFFFFE.
  - Latency is 33 edges, or 1 edge with MDU_FAST_MUL_EN defined.
- Corner cases:
  - DIVU a=5, b=0 → done next cycle, div_by_zero=1, lo=0xFFFFFFFF, hi=5.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Cancel/handshake:
  - Start DIV, then cancel at CALC cycle 10 → no done, hi/lo keep prior values.
  - Start pulses issued while busy → ignored.
  - Start issued in the DONE cycle → accepted, second done 33 edges later.
- Parametrisation: WIDTH=8, DIVU a=200, b=9 → lo=22, hi=2, done after 9 edges.
